// File: rtl/pong_sound_gen.sv
// Purpose : turns one-cycle Pong game-event pulses (paddle, wall, miss) into square-wave tones on Speaker.
// Latency : the event is sampled at edge t; the tone state, Busy=1 and Speaker=0 all appear after edge t.
//           The first Speaker rise follows H clocks later.
// Backpres: none. An event below the priority of the current tone is dropped. An event of equal or higher
//           priority restarts its tone from the beginning.
//
// Ports:
//   Clock     in   system clock
//   Reset     in   synchronous, active-high; clears state, counters and outputs
//   PaddleHit in   one-cycle pulse, ball struck paddle     (priority 2)
//   WallHit   in   one-cycle pulse, ball struck a wall     (priority 1)
//   Miss      in   one-cycle pulse, ball left the field    (priority 3, two-note tone)
//   Speaker   out  registered square wave
//   Busy      out  registered, high while any tone segment is playing
module pong_sound_gen #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned HALF_PADDLE = 104167,
  parameter int unsigned HALF_WALL   = 208333,
  parameter int unsigned HALF_MISS_A = 156250,
  parameter int unsigned HALF_MISS_B = 416667,
  parameter int unsigned DUR_SHORT   = 5000000,
  parameter int unsigned DUR_LONG    = 15000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic PaddleHit,
  input  logic WallHit,
  input  logic Miss,
  output logic Speaker,
  output logic Busy
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [1:0]       prio_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PADDLE = 3'd1,
    ST_WALL   = 3'd2,
    ST_MISS_A = 3'd3,
    ST_MISS_B = 3'd4
  } state_t;

  // Terminal counts are stored as H-1 / D-1, so the comparisons below are simple equality checks.
  localparam cnt_t HT_PADDLE = cnt_t'(HALF_PADDLE - 1);
  localparam cnt_t HT_WALL   = cnt_t'(HALF_WALL - 1);
  localparam cnt_t HT_MISS_A = cnt_t'(HALF_MISS_A - 1);
  localparam cnt_t HT_MISS_B = cnt_t'(HALF_MISS_B - 1);
  localparam cnt_t DT_SHORT  = cnt_t'(DUR_SHORT - 1);
  localparam cnt_t DT_LONG   = cnt_t'(DUR_LONG - 1);

  localparam prio_t PRIO_NONE   = 2'd0;
  localparam prio_t PRIO_WALL   = 2'd1;
  localparam prio_t PRIO_PADDLE = 2'd2;
  localparam prio_t PRIO_MISS   = 2'd3;

  state_t state_q, state_d;
  cnt_t   half_q,  half_d;
  cnt_t   dur_q,   dur_d;
  logic   speaker_q, speaker_d;
  logic   busy_q,    busy_d;

  // Event arbitration
  prio_t  req_prio;
  state_t req_state;
  prio_t  cur_prio;
  logic   accept;

  // Current segment parameters
  cnt_t   half_term;
  cnt_t   dur_term;
  state_t seg_next;
  logic   active;
  logic   half_wrap;
  logic   seg_end;

  // Fixed-priority encoder over the incoming pulses. Only the winner is seen downstream.
  always_comb begin
    req_prio  = PRIO_NONE;
    req_state = ST_IDLE;
    if (Miss) begin
      req_prio  = PRIO_MISS;
      req_state = ST_MISS_A;
    end else if (PaddleHit) begin
      req_prio  = PRIO_PADDLE;
      req_state = ST_PADDLE;
    end else if (WallHit) begin
      req_prio  = PRIO_WALL;
      req_state = ST_WALL;
    end
  end

  // Both miss notes share miss priority, so a new Miss also restarts from note 1 during note 2.
  always_comb begin
    cur_prio = PRIO_NONE;
    unique case (state_q)
      ST_IDLE:   cur_prio = PRIO_NONE;
      ST_WALL:   cur_prio = PRIO_WALL;
      ST_PADDLE: cur_prio = PRIO_PADDLE;
      ST_MISS_A: cur_prio = PRIO_MISS;
      ST_MISS_B: cur_prio = PRIO_MISS;
      default:   cur_prio = PRIO_NONE;
    endcase
  end

  // An event is taken when its priority is at least that of the playing tone.
  // In IDLE the current priority is NONE, so any event is taken.
  assign accept = (req_prio != PRIO_NONE) && (req_prio >= cur_prio);

  // Segment lookup: half-period terminal, duration terminal and the state that follows the segment.
  always_comb begin
    half_term = '0;
    dur_term  = '0;
    seg_next  = ST_IDLE;
    unique case (state_q)
      ST_PADDLE: begin
        half_term = HT_PADDLE;
        dur_term  = DT_SHORT;
        seg_next  = ST_IDLE;
      end
      ST_WALL: begin
        half_term = HT_WALL;
        dur_term  = DT_SHORT;
        seg_next  = ST_IDLE;
      end
      ST_MISS_A: begin
        half_term = HT_MISS_A;
        dur_term  = DT_LONG;
        seg_next  = ST_MISS_B;
      end
      ST_MISS_B: begin
        half_term = HT_MISS_B;
        dur_term  = DT_LONG;
        seg_next  = ST_IDLE;
      end
      default: begin
        half_term = '0;
        dur_term  = '0;
        seg_next  = ST_IDLE;
      end
    endcase
  end

  assign active    = (state_q != ST_IDLE);
  assign half_wrap = active && (half_q == half_term);
  assign seg_end   = active && (dur_q == dur_term);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      half_q    <= '0;
      dur_q     <= '0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      dur_q     <= dur_d;
      speaker_q <= speaker_d;
      busy_q    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  // A newly accepted event takes precedence over a coincident segment end. The new tone then
  // starts fresh instead of being followed into the next segment.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    dur_d   = dur_q;
    if (accept) begin
      state_d = req_state;
      half_d  = '0;
      dur_d   = '0;
    end else if (!active) begin
      state_d = ST_IDLE;
      half_d  = '0;
      dur_d   = '0;
    end else if (seg_end) begin
      state_d = seg_next;
      half_d  = '0;
      dur_d   = '0;
    end else begin
      half_d  = half_wrap ? '0 : half_q + cnt_t'(1);
      dur_d   = dur_q + cnt_t'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (registered through speaker_q / busy_q)
  // ---------------------------------------------------------------------------
  // Every segment starts low. A segment end forces Speaker low even when a toggle is due on the same
  // edge, so MISS_A -> MISS_B restarts cleanly.
  always_comb begin
    speaker_d = speaker_q;
    if (accept || seg_end || !active) begin
      speaker_d = 1'b0;
    end else if (half_wrap) begin
      speaker_d = ~speaker_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign Speaker = speaker_q;
  assign Busy    = busy_q;

  // Counters never pass their terminal value, and Busy tracks the state register.
  a_half_bound: assert property (@(posedge Clock) disable iff (Reset) half_q <= half_term);
  a_dur_bound:  assert property (@(posedge Clock) disable iff (Reset) dur_q <= dur_term);
  a_busy_state: assert property (@(posedge Clock) disable iff (Reset) busy_q == active);

endmodule

// File: tb/tb_pong_sound_gen.sv
// Purpose : directed checks of pong_sound_gen using short bench parameters.
// Latency : outputs are sampled 1 ns after each rising edge. Inputs change at the same point.
// Backpres: n/a.
module tb_pong_sound_gen;

  localparam int CNT_W = 8;
  localparam int H_PAD = 4;
  localparam int H_WAL = 8;
  localparam int H_MA  = 6;
  localparam int H_MB  = 12;
  localparam int D_S   = 40;
  localparam int D_L   = 48;

  logic clk = 1'b0;
  logic rst;
  logic paddle_hit;
  logic wall_hit;
  logic miss;
  logic speaker;
  logic busy;

  int checks = 0;
  int failures = 0;

  pong_sound_gen #(
    .CNT_W      (CNT_W),
    .HALF_PADDLE(H_PAD),
    .HALF_WALL  (H_WAL),
    .HALF_MISS_A(H_MA),
    .HALF_MISS_B(H_MB),
    .DUR_SHORT  (D_S),
    .DUR_LONG   (D_L)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .PaddleHit(paddle_hit),
    .WallHit  (wall_hit),
    .Miss     (miss),
    .Speaker  (speaker),
    .Busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check segment cycles j0..j0+n-1, counted from 1 at segment entry, and step after each one.
  // The expected wave is low for the first H cycles, then alternates every H cycles.
  task automatic expect_seg(input string tag, input int h, input int j0, input int n);
    for (int j = j0; j < j0 + n; j++) begin
      chk($sformatf("%s_spk_j%0d", tag, j), {31'd0, speaker}, ((j - 1) / h) % 2);
      chk($sformatf("%s_busy_j%0d", tag, j), {31'd0, busy}, 1);
      step();
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_busy_%0d", tag, k), {31'd0, busy}, 0);
      chk($sformatf("%s_spk_%0d", tag, k), {31'd0, speaker}, 0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    paddle_hit = 1'b0;
    wall_hit = 1'b0;
    miss = 1'b0;

    // 1. Reset state, then quiet
    step(); step(); step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_spk", {31'd0, speaker}, 0);
    rst = 1'b0;
    expect_idle("quiet", 100);

    // 2. Paddle tone: 40 busy cycles, first rise 5 cycles after the pulse cycle
    paddle_hit = 1'b1; step(); paddle_hit = 1'b0;
    expect_seg("pad", H_PAD, 1, D_S);
    expect_idle("pad_end", 5);

    // 3. Miss: two seamless 48-cycle notes
    miss = 1'b1; step(); miss = 1'b0;
    expect_seg("missa", H_MA, 1, D_L);
    expect_seg("missb", H_MB, 1, D_L);
    expect_idle("miss_end", 5);

    // 4a. Wall tone pre-empted by paddle in its 10th cycle
    wall_hit = 1'b1; step(); wall_hit = 1'b0;
    expect_seg("wall", H_WAL, 1, 9);
    paddle_hit = 1'b1;
    expect_seg("wall", H_WAL, 10, 1);
    paddle_hit = 1'b0;
    expect_seg("pad_pre", H_PAD, 1, D_S);
    expect_idle("pad_pre_end", 3);

    // 4b. Wall during a paddle tone is dropped and the end time is unchanged
    paddle_hit = 1'b1; step(); paddle_hit = 1'b0;
    expect_seg("pad_w", H_PAD, 1, 15);
    wall_hit = 1'b1;
    expect_seg("pad_w", H_PAD, 16, 1);
    wall_hit = 1'b0;
    expect_seg("pad_w", H_PAD, 17, D_S - 16);
    expect_idle("pad_w_end", 3);

    // Paddle on the last paddle cycle: the new event wins and restarts the tone
    paddle_hit = 1'b1; step(); paddle_hit = 1'b0;
    expect_seg("pad_e", H_PAD, 1, D_S - 1);
    paddle_hit = 1'b1;
    expect_seg("pad_e", H_PAD, D_S, 1);
    paddle_hit = 1'b0;
    expect_seg("pad_re", H_PAD, 1, D_S);
    expect_idle("pad_re_end", 3);

    // 5a. All three pulses in the same cycle: only the miss tone plays
    paddle_hit = 1'b1; wall_hit = 1'b1; miss = 1'b1;
    step();
    paddle_hit = 1'b0; wall_hit = 1'b0; miss = 1'b0;
    expect_seg("all_a", H_MA, 1, D_L);
    expect_seg("all_b", H_MB, 1, D_L);
    expect_idle("all_end", 3);

    // 5b. Miss during MISS_B restarts at MISS_A
    miss = 1'b1; step(); miss = 1'b0;
    expect_seg("rm_a", H_MA, 1, D_L);
    expect_seg("rm_b", H_MB, 1, 10);
    miss = 1'b1;
    expect_seg("rm_b", H_MB, 11, 1);
    miss = 1'b0;
    expect_seg("rm_a2", H_MA, 1, D_L);
    expect_seg("rm_b2", H_MB, 1, D_L);
    expect_idle("rm_end", 3);

    // 6. Reset in cycle 20 of a miss tone (Speaker is high there), with a PaddleHit on the same edge
    miss = 1'b1; step(); miss = 1'b0;
    expect_seg("rs_a", H_MA, 1, 19);
    chk("rs_spk_before", {31'd0, speaker}, 1);
    rst = 1'b1; paddle_hit = 1'b1;
    step();
    rst = 1'b0; paddle_hit = 1'b0;
    expect_idle("rs_after", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
